cache: RTL and testbench
========================

Name: cache

Overview:
- Small 2-way set-associative, write-back, write-allocate data cache.
- 8-bit data, 8-bit tag, 2-bit set index; 4 sets × 2 ways = 8 lines.
- Sits in front of an internal 1024×8 backing store addressed by {tag, index}.
- Accepts one read or write operation per clock, with no handshake. The memory-side test harness drives it with a packed 19-bit instruction {mode, index, tag, data}.

Parameters:
- None. Widths are fixed: INDEX=2, TAG=8, DATA=8, WAYS=2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- index  input  2  set index (instruction bits [17:16]).
- tag  input  8  address tag (instruction bits [15:8]).
- data_in  input  8  write data (instruction bits [7:0]); ignored on reads.
- mode  input  1  operation select: 1 = write, 0 = read (instruction bit [18]).
- data_out  output  8  registered result of the last operation.
- hit  output  1  registered; 1 if the last operation hit in the cache.

Behaviour:
- Storage per line: valid, dirty, tag[7:0], data[7:0]. Each set also has one LRU bit, which names the least-recently-used way.
- Backing store: 1024×8, address {tag, index}. Every entry is zero at time 0. Reset does NOT clear it.
- Reset (asynchronous, active-high), effective immediately:
  - all valid, dirty and LRU bits cleared;
  - data_out = 0x00, hit = 0.
  - Reset asserted mid-stream discards the in-flight operation; the backing store keeps prior contents.
- Operation: one operation is sampled and completed at every rising clock edge while reset is low. Latency is 1 cycle; results appear on data_out/hit after that edge.
- Lookup: a way hits when it is valid and its stored tag equals tag. At most one way can match.
- Read hit: data_out <= line data; hit <= 1; that way becomes MRU (LRU bit <= other way).
- Read miss:
  - hit <= 0.
  - Victim choice: first invalid way (way0 before way1); otherwise the LRU way.
  - If the victim is valid and dirty, write its data to backing[{victim tag, index}] in the same edge.
  - Fill the victim with backing[{tag, index}]: valid=1, dirty=0, tag stored.
  - data_out <= filled data; victim becomes MRU.
  - The fill reads the backing store before the write-back, so the pre-edge value is used. The addresses differ anyway, because the tags differ.
- Write hit: line data <= data_in; dirty <= 1; data_out <= data_in; hit <= 1; way becomes MRU.
- Write miss (write-allocate):
  - Choose the victim and write it back if dirty, exactly as for a read miss.
  - Fill the victim with data_in, tag, valid=1, dirty=1.
  - data_out <= data_in; hit <= 0; victim becomes MRU.
  - The backing store is not updated with data_in (write-back policy).
- Sets are fully independent; an operation touches only the addressed set.
- Simultaneous events: none beyond the above; there is a single port and one operation per cycle.

Test Plan:
- Reset, then write mode=1 idx=1 tag=0x00 data=0xFF -> hit=0, data_out=0xFF. Then read idx=1 tag=0x00 -> hit=1, data_out=0xFF.
- Write mode=1 idx=3 tag=0x00 data=0x01 -> hit=0, data_out=0x01. Then read idx=3 tag=0x00 -> hit=1, data_out=0x01. Set 1 is unaffected: read idx=1 tag=0x00 -> 0xFF, hit=1.
- Read idx=2 tag=0x55 on a cold cache -> hit=0, data_out=0x00 (backing store zero). Repeat -> hit=1, data_out=0x00.
- Eviction and write-back in set 0:
  - write tag 0x10 data 0xAA; write tag 0x20 data 0xBB; read tag 0x10 (hit, 0xAA, makes tag 0x20 LRU).
  - write tag 0x30 data 0xCC -> evicts tag 0x20 (dirty, written back).
  - read tag 0x20 -> hit=0, data_out=0xBB. This evicts tag 0x10, which is LRU because tag 0x30 was accessed more recently.
  - read tag 0x10 -> hit=0, data_out=0xAA.
- Write hit then re-read: write idx=0 tag=0x40 data=0x11, write same address data=0x22 -> second write hit=1. A subsequent read returns 0x22 with hit=1.
- Assert reset asynchronously mid-sequence -> data_out=0x00 and hit=0 immediately. Reading a previously cached, never-evicted address afterwards misses (hit=0) and returns the stale backing value (0x00 if it was never written back).

Source files
------------

// File: rtl/cache_if.sv
// rtl/cache_if.sv - single-port operation bus of the 2-way set-associative cache
interface cache_if;
    logic [1:0] index;
    logic [7:0] tag;
    logic [7:0] data_in;
    logic       mode;
    logic [7:0] data_out;
    logic       hit;

    modport master (output index, output tag, output data_in, output mode,
                    input data_out, input hit);
    modport slave  (input index, input tag, input data_in, input mode,
                    output data_out, output hit);
endinterface

// File: rtl/cache.sv
// rtl/cache.sv - 4-set 2-way write-back write-allocate cache over a 1024x8 backing store
module cache (
    input  logic   clock,
    input  logic   reset,
    cache_if.slave bus
);
    logic [1:0] valid [4];
    logic [1:0] dirty [4];
    logic [3:0] lru;
    logic [7:0] tags  [4][2];
    logic [7:0] lines [4][2];
    logic [7:0] backing [1024] = '{default: 8'h00};

    logic [1:0] idx;
    logic [1:0] match;
    logic       hit_any;
    logic       victim;
    logic       way;
    logic       wb_en;
    logic [9:0] rd_addr;
    logic [9:0] wb_addr;
    logic [7:0] fill_data;
    logic [7:0] new_data;

    assign idx      = bus.index;
    assign match[0] = valid[idx][0] && (tags[idx][0] == bus.tag);
    assign match[1] = valid[idx][1] && (tags[idx][1] == bus.tag);
    assign hit_any  = |match;

    // Invalid ways are filled first (way0 before way1); only a full set falls back to LRU.
    assign victim = !valid[idx][0] ? 1'b0 :
                    !valid[idx][1] ? 1'b1 : lru[idx];
    assign way    = hit_any ? match[1] : victim;

    assign rd_addr   = {bus.tag, idx};
    assign fill_data = backing[rd_addr];
    assign wb_en     = !hit_any && valid[idx][victim] && dirty[idx][victim];
    assign wb_addr   = {tags[idx][victim], idx};

    assign new_data = bus.mode ? bus.data_in :
                      hit_any  ? lines[idx][way] : fill_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 4; s++) begin
                valid[s] <= 2'b00;
                dirty[s] <= 2'b00;
            end
            lru          <= 4'b0000;
            bus.data_out <= 8'h00;
            bus.hit      <= 1'b0;
        end else begin
            valid[idx][way] <= 1'b1;
            if (bus.mode) begin
                dirty[idx][way] <= 1'b1;
            end else if (!hit_any) begin
                dirty[idx][way] <= 1'b0;
            end
            lru[idx]     <= ~way;
            bus.data_out <= new_data;
            bus.hit      <= hit_any;
        end
    end

    // Line payload needs no reset: valid bits are cleared asynchronously, so any
    // write landing here while reset is high goes to an invalid line and wb_en stays low.
    always_ff @(posedge clock) begin
        lines[idx][way] <= new_data;
        tags[idx][way]  <= bus.tag;
        if (wb_en) begin
            backing[wb_addr] <= lines[idx][victim];
        end
    end
endmodule

// File: tb/tb_cache.sv
// tb/tb_cache.sv - self-checking bench for cache against a recency-list reference model
module tb_cache;
    logic clock = 1'b0;
    logic reset = 1'b1;
    cache_if bus ();

    cache dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] data;
        logic       dirty;
    } line_t;

    typedef struct packed {
        logic       m;
        logic [1:0] i;
        logic [7:0] t;
        logic [7:0] d;
        logic       eh;
        logic [7:0] ed;
    } vec_t;

    // Reference: each set is a recency list, slot 0 = most recent, at most two entries.
    line_t      lst [4][2];
    int         cnt [4];
    logic [7:0] bmem [1024];

    task automatic model_reset();
        for (int s = 0; s < 4; s++) cnt[s] = 0;
    endtask

    task automatic model_op(input logic m, input logic [1:0] i, input logic [7:0] t,
                            input logic [7:0] d, output logic [7:0] ed, output logic eh);
        int    pos;
        line_t ln;
        pos = -1;
        for (int k = 0; k < cnt[i]; k++) if (lst[i][k].tag == t) pos = k;
        if (pos >= 0) begin
            eh = 1'b1;
            ln = lst[i][pos];
            if (m) begin
                ln.data  = d;
                ln.dirty = 1'b1;
            end
            if (pos == 1) lst[i][1] = lst[i][0];
            lst[i][0] = ln;
        end else begin
            eh       = 1'b0;
            ln.tag   = t;
            ln.data  = m ? d : bmem[{t, i}];
            ln.dirty = m;
            if (cnt[i] == 2 && lst[i][1].dirty) bmem[{lst[i][1].tag, i}] = lst[i][1].data;
            if (cnt[i] >= 1) lst[i][1] = lst[i][0];
            lst[i][0] = ln;
            if (cnt[i] < 2) cnt[i] = cnt[i] + 1;
        end
        ed = ln.data;
    endtask

    task automatic drive(input logic m, input logic [1:0] i, input logic [7:0] t, input logic [7:0] d);
        @(negedge clock);
        bus.mode    = m;
        bus.index   = i;
        bus.tag     = t;
        bus.data_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic run_table(input string name, input vec_t v [], input int n);
        logic [7:0] ed;
        logic       eh;
        for (int k = 0; k < n; k++) begin
            drive(v[k].m, v[k].i, v[k].t, v[k].d);
            model_op(v[k].m, v[k].i, v[k].t, v[k].d, ed, eh);
            total++;
            if (bus.hit !== v[k].eh || bus.data_out !== v[k].ed)
                $display("FAIL %s step %0d: hit=%b data_out=%h, required hit=%b data_out=%h",
                         name, k, bus.hit, bus.data_out, v[k].eh, v[k].ed);
            else passed++;
        end
    endtask

    task automatic test_reset();
        bus.mode = 1'b0; bus.index = 2'd0; bus.tag = 8'h00; bus.data_in = 8'h00;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        total++;
        if (bus.hit !== 1'b0 || bus.data_out !== 8'h00)
            $display("FAIL reset_state: hit=%b data_out=%h, required hit=0 data_out=00", bus.hit, bus.data_out);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        vec_t v [];
        v = new[5];
        v[0] = '{1'b1, 2'd1, 8'h00, 8'hFF, 1'b0, 8'hFF};
        v[1] = '{1'b0, 2'd1, 8'h00, 8'h00, 1'b1, 8'hFF};
        v[2] = '{1'b1, 2'd3, 8'h00, 8'h01, 1'b0, 8'h01};
        v[3] = '{1'b0, 2'd3, 8'h00, 8'h00, 1'b1, 8'h01};
        v[4] = '{1'b0, 2'd1, 8'h00, 8'h00, 1'b1, 8'hFF};
        run_table("basic", v, 5);
    endtask

    task automatic test_cold_read();
        vec_t v [];
        v = new[2];
        v[0] = '{1'b0, 2'd2, 8'h55, 8'h9C, 1'b0, 8'h00};
        v[1] = '{1'b0, 2'd2, 8'h55, 8'h00, 1'b1, 8'h00};
        run_table("cold_read", v, 2);
    endtask

    task automatic test_eviction();
        vec_t v [];
        v = new[6];
        v[0] = '{1'b1, 2'd0, 8'h10, 8'hAA, 1'b0, 8'hAA};
        v[1] = '{1'b1, 2'd0, 8'h20, 8'hBB, 1'b0, 8'hBB};
        v[2] = '{1'b0, 2'd0, 8'h10, 8'h00, 1'b1, 8'hAA};
        v[3] = '{1'b1, 2'd0, 8'h30, 8'hCC, 1'b0, 8'hCC};
        v[4] = '{1'b0, 2'd0, 8'h20, 8'h00, 1'b0, 8'hBB};
        v[5] = '{1'b0, 2'd0, 8'h10, 8'h00, 1'b0, 8'hAA};
        run_table("eviction", v, 6);
    endtask

    task automatic test_write_hit();
        vec_t v [];
        v = new[3];
        v[0] = '{1'b1, 2'd0, 8'h40, 8'h11, 1'b0, 8'h11};
        v[1] = '{1'b1, 2'd0, 8'h40, 8'h22, 1'b1, 8'h22};
        v[2] = '{1'b0, 2'd0, 8'h40, 8'h00, 1'b1, 8'h22};
        run_table("write_hit", v, 3);
    endtask

    task automatic test_async_reset();
        vec_t v [];
        @(negedge clock);
        bus.mode = 1'b0; bus.index = 2'd1; bus.tag = 8'h00; bus.data_in = 8'h00;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.hit !== 1'b0 || bus.data_out !== 8'h00)
            $display("FAIL async_reset: hit=%b data_out=%h, required hit=0 data_out=00", bus.hit, bus.data_out);
        else passed++;
        model_reset();
        bus.mode = 1'b1; bus.index = 2'd3; bus.tag = 8'h77; bus.data_in = 8'h5A;
        @(posedge clock);
        #1;
        total++;
        if (bus.hit !== 1'b0 || bus.data_out !== 8'h00)
            $display("FAIL reset_discard: hit=%b data_out=%h, required hit=0 data_out=00", bus.hit, bus.data_out);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        v = new[2];
        v[0] = '{1'b0, 2'd0, 8'h40, 8'h00, 1'b0, 8'h00};
        v[1] = '{1'b0, 2'd0, 8'h20, 8'h00, 1'b0, 8'hBB};
        run_table("after_reset", v, 2);
    endtask

    task automatic test_random();
        logic       m, eh;
        logic [1:0] i;
        logic [7:0] t, d, ed;
        for (int k = 0; k < 400; k++) begin
            m = 1'($urandom_range(0, 1));
            i = 2'($urandom_range(0, 3));
            t = 8'($urandom_range(0, 3)) << 6 | 8'($urandom_range(0, 1));
            d = 8'($urandom);
            drive(m, i, t, d);
            model_op(m, i, t, d, ed, eh);
            total++;
            if (bus.hit !== eh || bus.data_out !== ed)
                $display("FAIL random op %0d (m=%b i=%0d t=%h d=%h): hit=%b data_out=%h, required hit=%b data_out=%h",
                         k, m, i, t, d, bus.hit, bus.data_out, eh, ed);
            else passed++;
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) bmem[a] = 8'h00;
        model_reset();
        test_reset();
        test_basic();
        test_cold_read();
        test_eviction();
        test_write_hit();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
